// File: rtl/sie_defs_pkg.sv
// sie_defs_pkg: shared SIE type definitions for the receive packet buffer
// Contents: RxBufStates, the receive buffer control states.
package sie_defs_pkg;
    typedef enum logic [1:0] {IDLE, RECEIVE, FLUSH} RxBufStates;
endpackage

// File: rtl/usb_rx_packet_buffer_if.sv
// usb_rx_packet_buffer_if: decoder-to-buffer and buffer-to-backend signal bundle
// Decoder side: rxPacketStart, rxByteValid, rxByte, rxPacketEnd, rxPacketError, trailCount.
// Backend side: rxAcceptNewData in, rxDataValid/rxData/rxIsLastByte/keepPacket out.
// master drives decoder and backend inputs; slave is the packet buffer.
interface usb_rx_packet_buffer_if #(
    parameter int DATA_W = 8,
    parameter int MAX_TRAIL = 2
);
    logic                             rxPacketStart;
    logic                             rxByteValid;
    logic [DATA_W-1:0]                rxByte;
    logic                             rxPacketEnd;
    logic                             rxPacketError;
    logic [$clog2(MAX_TRAIL+1)-1:0]   trailCount;
    logic                             rxAcceptNewData;
    logic                             rxDataValid;
    logic [DATA_W-1:0]                rxData;
    logic                             rxIsLastByte;
    logic                             keepPacket;
    modport master (
        output rxPacketStart, rxByteValid, rxByte, rxPacketEnd, rxPacketError, trailCount,
        output rxAcceptNewData,
        input  rxDataValid, rxData, rxIsLastByte, keepPacket
    );
    modport slave (
        input  rxPacketStart, rxByteValid, rxByte, rxPacketEnd, rxPacketError, trailCount,
        input  rxAcceptNewData,
        output rxDataValid, rxData, rxIsLastByte, keepPacket
    );
endinterface

// File: rtl/usb_rx_byte_fifo.sv
// usb_rx_byte_fifo: first-word fall-through FIFO holding {last, keep, byte} entries
// Ports: clk48/RST clock and sync reset; wrEn/wrData push; rdEn pop;
// rdData head entry (valid when !empty); full/empty status.
// Caller only pushes when !full or popping in the same cycle, and only pops when !empty.
module usb_rx_byte_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             clk48,
    input  logic             RST,
    input  logic             wrEn,
    input  logic [WIDTH-1:0] wrData,
    input  logic             rdEn,
    output logic [WIDTH-1:0] rdData,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr, rdPtr;
    assign empty  = wrPtr == rdPtr;
    assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign rdData = mem[rdPtr[AW-1:0]];
    always_ff @(posedge clk48) begin
        if (RST) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (wrEn) wrPtr <= wrPtr + 1'b1;
            if (rdEn) rdPtr <= rdPtr + 1'b1;
        end
    end
    always_ff @(posedge clk48) begin
        if (wrEn) mem[wrPtr[AW-1:0]] <= wrData;
    end
endmodule

// File: rtl/usb_rx_packet_buffer.sv
// usb_rx_packet_buffer: holds back trailing CRC bytes and queues packet bytes with last/keep tags
// Ports: clk48 clock; RST sync active-high reset; bus (slave) carries decoder
// strobes in and the FWFT byte stream with rxIsLastByte/keepPacket out.
module usb_rx_packet_buffer
    import sie_defs_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_TRAIL = 2
) (
    input logic                clk48,
    input logic                RST,
    usb_rx_packet_buffer_if.slave bus
);
    localparam int HOLD = MAX_TRAIL + 1;
    localparam int HW = $clog2(HOLD + 1);
    localparam int IW = $clog2(HOLD);
    localparam int TW = $clog2(MAX_TRAIL + 1);
    RxBufStates        state, stateNext;
    logic [DATA_W-1:0] hold [HOLD];
    logic [HW-1:0]     h, hNext, n, nNext, trailSat;
    logic [IW-1:0]     oldIdx;
    logic              overflow, overflowNext, protoErr, protoErrNext, err, errNext;
    logic              shiftIn, pushReq, push, pop, canPush, full, empty;
    logic [DATA_W+1:0] pushWord, headWord;
    assign pop      = !empty && bus.rxAcceptNewData;
    assign canPush  = !full || pop;
    assign push     = pushReq && canPush;
    assign oldIdx   = IW'(h - HW'(1));
    assign trailSat = (bus.trailCount > TW'(MAX_TRAIL)) ? HW'(MAX_TRAIL) : HW'(bus.trailCount);
    always_comb begin
        stateNext    = state;
        hNext        = h;
        nNext        = n;
        overflowNext = overflow;
        protoErrNext = protoErr;
        errNext      = err;
        shiftIn      = 1'b0;
        pushReq      = 1'b0;
        pushWord     = '0;
        case (state)
            IDLE: begin
                if (bus.rxPacketStart) begin
                    stateNext    = RECEIVE;
                    hNext        = '0;
                    overflowNext = 1'b0;
                    protoErrNext = 1'b0;
                end
            end
            RECEIVE: begin
                if (bus.rxPacketStart) protoErrNext = 1'b1;
                if (bus.rxByteValid) begin
                    shiftIn = 1'b1;
                    // A full hold line releases its oldest byte: it can no longer be a trailer.
                    if (h == HW'(HOLD)) begin
                        pushReq  = 1'b1;
                        pushWord = {1'b0, 1'b1, hold[HOLD-1]};
                        if (!canPush) overflowNext = 1'b1;
                    end else begin
                        hNext = h + HW'(1);
                    end
                end
                if (bus.rxPacketEnd) begin
                    nNext     = (hNext > trailSat) ? hNext - trailSat : '0;
                    errNext   = bus.rxPacketError | overflowNext | protoErrNext;
                    stateNext = (nNext == '0) ? IDLE : FLUSH;
                end
            end
            FLUSH: begin
                pushReq  = 1'b1;
                pushWord = {n == HW'(1), (n == HW'(1)) ? ~err : 1'b1, hold[oldIdx]};
                if (canPush) begin
                    hNext = h - HW'(1);
                    nNext = n - HW'(1);
                    if (n == HW'(1)) stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end
    always_ff @(posedge clk48) begin
        if (RST) begin
            state    <= IDLE;
            h        <= '0;
            n        <= '0;
            overflow <= 1'b0;
            protoErr <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= stateNext;
            h        <= hNext;
            n        <= nNext;
            overflow <= overflowNext;
            protoErr <= protoErrNext;
            err      <= errNext;
        end
    end
    // Newest byte at index 0, oldest held byte at index h-1.
    always_ff @(posedge clk48) begin
        if (shiftIn) begin
            hold[0] <= bus.rxByte;
            for (int i = 1; i < HOLD; i++) hold[i] <= hold[i-1];
        end
    end
    usb_rx_byte_fifo #(.WIDTH(DATA_W + 2), .DEPTH(FIFO_DEPTH)) fifo (
        .clk48  (clk48),
        .RST    (RST),
        .wrEn   (push),
        .wrData (pushWord),
        .rdEn   (pop),
        .rdData (headWord),
        .full   (full),
        .empty  (empty)
    );
    assign bus.rxDataValid  = !empty;
    assign bus.rxData       = empty ? '0 : headWord[DATA_W-1:0];
    assign bus.rxIsLastByte = !empty && headWord[DATA_W+1];
    assign bus.keepPacket   = empty || headWord[DATA_W];
endmodule

// File: tb/tb_usb_rx_packet_buffer.sv
// tb_usb_rx_packet_buffer: scoreboard bench for the receive packet buffer (FIFO_DEPTH=4)
module tb_usb_rx_packet_buffer;
    logic clk48 = 1'b0;
    logic RST = 1'b1;
    always #5 clk48 = ~clk48;

    usb_rx_packet_buffer_if #(.DATA_W(8), .MAX_TRAIL(2)) bus ();
    usb_rx_packet_buffer #(.DATA_W(8), .FIFO_DEPTH(4), .MAX_TRAIL(2)) dut (
        .clk48 (clk48),
        .RST   (RST),
        .bus   (bus)
    );

    int nPass = 0;
    int nChecks = 0;
    logic [9:0] expQ[$];
    logic [9:0] expHead;
    logic [7:0] pkt[$];
    bit toggleMode = 1'b0;
    bit readyLevel = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: drop min(trail,2) trailing bytes; last kept byte tagged with keep=~err.
    function automatic void expectPacket(input int trail, input bit err);
        int t = (trail > 2) ? 2 : trail;
        int n = (pkt.size() > t) ? pkt.size() - t : 0;
        for (int i = 0; i < n; i++)
            expQ.push_back({i == n - 1, (i == n - 1) ? ~err : 1'b1, pkt[i]});
    endfunction

    task automatic tick();
        @(posedge clk48);
        #1;
    endtask

    task automatic idleIns();
        bus.rxPacketStart = 1'b0;
        bus.rxByteValid   = 1'b0;
        bus.rxByte        = '0;
        bus.rxPacketEnd   = 1'b0;
        bus.rxPacketError = 1'b0;
        bus.trailCount    = '0;
    endtask

    task automatic sendPacket(input int trail, input bit err, input bit endWithLast);
        bus.rxPacketStart = 1'b1;
        tick();
        bus.rxPacketStart = 1'b0;
        for (int i = 0; i < pkt.size(); i++) begin
            bus.rxByteValid = 1'b1;
            bus.rxByte = pkt[i];
            if (endWithLast && i == pkt.size() - 1) begin
                bus.rxPacketEnd = 1'b1;
                bus.trailCount = 2'(trail);
                bus.rxPacketError = err;
            end
            tick();
        end
        bus.rxByteValid = 1'b0;
        if (!endWithLast) begin
            bus.rxPacketEnd = 1'b1;
            bus.trailCount = 2'(trail);
            bus.rxPacketError = err;
            tick();
        end
        idleIns();
    endtask

    task automatic waitDrain(input int budget);
        int c = 0;
        while ((expQ.size() != 0 || bus.rxDataValid) && c < budget) begin
            tick();
            c++;
        end
        check("drain pending", expQ.size(), 0);
        check("drain valid", bus.rxDataValid, 0);
    endtask

    task automatic checkEmpty(input string tag);
        check({tag, " valid"}, bus.rxDataValid, 0);
        check({tag, " data"}, bus.rxData, 0);
        check({tag, " last"}, bus.rxIsLastByte, 0);
        check({tag, " keep"}, bus.keepPacket, 1);
    endtask

    initial begin
        bus.rxAcceptNewData = 1'b1;
        forever begin
            @(posedge clk48);
            #1;
            bus.rxAcceptNewData = toggleMode ? ~bus.rxAcceptNewData : readyLevel;
        end
    end

    // Every accepted head entry is compared with the oldest scoreboard entry.
    always @(negedge clk48) begin
        if (!RST && bus.rxDataValid && bus.rxAcceptNewData) begin
            if (expQ.size() == 0) begin
                check("spurious entry", expQ.size(), 1);
            end else begin
                expHead = expQ.pop_front();
                check("entry {last,keep,data}", {22'b0, bus.rxIsLastByte, bus.keepPacket, bus.rxData}, {22'b0, expHead});
            end
        end
    end

    initial begin
        idleIns();
        repeat (3) tick();
        RST = 1'b0;
        checkEmpty("reset");

        pkt = '{8'hC3, 8'h01, 8'h02, 8'hAA, 8'hBB};
        expectPacket(2, 0);
        sendPacket(2, 0, 0);
        waitDrain(50);
        checkEmpty("idle after data");

        pkt = '{8'hD2};
        expectPacket(0, 0);
        sendPacket(0, 0, 0);
        waitDrain(50);

        // Short packet yields nothing; a start on the very next cycle must be accepted cleanly.
        pkt = '{8'h5A};
        sendPacket(2, 0, 0);
        pkt = '{8'h4B, 8'h11};
        expectPacket(0, 0);
        sendPacket(0, 0, 0);
        waitDrain(50);

        pkt = '{8'h10, 8'h20, 8'h30, 8'h40};
        expectPacket(2, 1);
        sendPacket(2, 1, 0);
        waitDrain(50);

        pkt = '{8'h61, 8'h62, 8'h63, 8'h64};
        expectPacket(1, 0);
        sendPacket(1, 0, 1);
        waitDrain(50);

        pkt = '{8'h71, 8'h72, 8'h73, 8'h74, 8'h75};
        expectPacket(3, 0);
        sendPacket(3, 0, 0);
        waitDrain(50);

        // Second start mid-packet poisons the packet but its bytes still flow.
        pkt = '{8'h11, 8'h22, 8'h33, 8'h44};
        expectPacket(0, 1);
        bus.rxPacketStart = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.rxPacketStart = (i == 2);
            bus.rxByteValid = 1'b1;
            bus.rxByte = pkt[i];
            tick();
        end
        idleIns();
        bus.rxPacketEnd = 1'b1;
        tick();
        idleIns();
        waitDrain(50);

        // Overflow with backend stalled: bytes 0..3 fit, 4..6 are lost, byte 7 is the last kept.
        readyLevel = 1'b0;
        repeat (2) tick();
        pkt.delete();
        for (int i = 0; i < 10; i++) pkt.push_back(8'(8'h80 + i));
        for (int i = 0; i < 4; i++) expQ.push_back({2'b01, pkt[i]});
        expQ.push_back({2'b10, pkt[7]});
        sendPacket(2, 0, 0);
        repeat (5) tick();
        check("ovf held valid", bus.rxDataValid, 1);
        check("ovf held head", bus.rxData, 8'h80);
        check("ovf held last", bus.rxIsLastByte, 0);
        readyLevel = 1'b1;
        waitDrain(50);

        // Reset mid-packet discards FIFO and hold line contents.
        readyLevel = 1'b0;
        repeat (2) tick();
        bus.rxPacketStart = 1'b1;
        tick();
        bus.rxPacketStart = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.rxByteValid = 1'b1;
            bus.rxByte = 8'(8'hE0 + i);
            tick();
        end
        idleIns();
        check("pre-reset valid", bus.rxDataValid, 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checkEmpty("mid reset");
        readyLevel = 1'b1;
        repeat (2) tick();
        pkt = '{8'h91, 8'h92, 8'h93};
        expectPacket(2, 0);
        sendPacket(2, 0, 0);
        waitDrain(50);

        // Three packets with ready toggling every cycle.
        toggleMode = 1'b1;
        for (int p = 0; p < 3; p++) begin
            int sizes[3] = '{5, 3, 6};
            int trails[3] = '{2, 0, 1};
            pkt.delete();
            for (int i = 0; i < sizes[p]; i++) pkt.push_back(8'(p * 16 + i + 1));
            expectPacket(trails[p], 0);
            sendPacket(trails[p], 0, 0);
            repeat (12) tick();
        end
        waitDrain(200);
        toggleMode = 1'b0;
        repeat (2) tick();
        checkEmpty("final");

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule

// File: doc/usb_rx_packet_buffer.md
USB_RX_PACKET_BUFFER -- requirements
Module: usb_rx_packet_buffer

Interface
REQ-001 Parameter DATA_W, default 8: received byte width.
REQ-002 Parameter FIFO_DEPTH, default 8: output FIFO entries; power of two, >=2.
REQ-003 Parameter MAX_TRAIL, default 2: maximum trailing (CRC) bytes strippable per packet.
REQ-004 clk48  in  1  sole clock; all logic on posedge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 rxPacketStart  in  1  one-cycle pulse; SYNC detected, new packet begins.
REQ-007 rxByteValid  in  1  one-cycle strobe; rxByte holds a new received byte.
REQ-008 rxByte  in  DATA_W  received byte (PID included).
REQ-009 rxPacketEnd  in  1  one-cycle pulse; EOP detected.
REQ-010 rxPacketError  in  1  decoder error (bit stuffing/PID/CRC); sampled with rxPacketEnd.
REQ-011 trailCount  in  $clog2(MAX_TRAIL+1)  trailing bytes to discard; sampled with rxPacketEnd; values >MAX_TRAIL treated as MAX_TRAIL.
REQ-012 rxAcceptNewData  in  1  backend ready.
REQ-013 rxDataValid  out  1  FIFO head valid.
REQ-014 rxData  out  DATA_W  FIFO head byte.
REQ-015 rxIsLastByte  out  1  head is the packet's last kept byte.
REQ-016 keepPacket  out  1  meaningful with rxIsLastByte; 0 = drop packet.

Function
REQ-017 States IDLE, RECEIVE, FLUSH; rxPacketStart in IDLE -> RECEIVE, hold line and sticky error cleared.
REQ-018 Hold line: MAX_TRAIL+1 bytes deep, with count h; in RECEIVE each rxByteValid shifts rxByte in; if h was MAX_TRAIL+1, the oldest byte is pushed to the FIFO in the same cycle.
REQ-019 FIFO push while full (no same-cycle pop): byte discarded, sticky overflow set.
REQ-020 rxPacketEnd in RECEIVE -> FLUSH; latch n = h - min(trailCount,MAX_TRAIL), saturating at 0; latch err = rxPacketError | overflow | protocol error.
REQ-021 rxByteValid and rxPacketEnd in the same cycle: byte is included before n is computed.
REQ-022 FLUSH pushes the oldest n held bytes, one per cycle; the n-th push carries last=1, keep=~err; FIFO full stalls FLUSH, no discard.
REQ-023 FLUSH -> IDLE in the cycle of the final push, or immediately when n=0 (no entry emitted).
REQ-024 rxPacketStart in RECEIVE or FLUSH: ignored, sets sticky protocol error.
REQ-025 rxByteValid in IDLE or FLUSH: ignored; rxPacketEnd outside RECEIVE: ignored.
REQ-026 Output is first-word fall-through: a push at cycle k is visible at cycle k+1.
REQ-027 Pop when rxDataValid & rxAcceptNewData; push and pop in the same cycle allowed, including when full.
REQ-028 FIFO empty: rxDataValid=0, rxData=0, rxIsLastByte=0, keepPacket=1.
REQ-029 Pointers are $clog2(FIFO_DEPTH)+1 bits; full/empty from the MSB compare; wrap-around is natural.

Reset
REQ-030 RST has priority over all inputs: state IDLE, h=0, FIFO pointers 0, sticky flags 0; outputs per REQ-028 in the following cycle.
REQ-031 RST mid-packet: all FIFO and hold contents lost; no last entry emitted for the aborted packet.

Structure
REQ-032 Enum RxBufStates (IDLE, RECEIVE, FLUSH) resides in sie_defs_pkg.
REQ-033 FIFO storage and pointers are sub-module usb_rx_byte_fifo (parameters DATA_W+2, FIFO_DEPTH; FWFT).

Verification
REQ-034 DATA packet: start, bytes C3 01 02 AA BB, end with trailCount=2, no error -> outputs C3, 01, 02; last=1 on 02; keepPacket=1.
REQ-035 ACK packet: start, byte D2, end with trailCount=0 -> single entry D2 with last=1, keep=1.
REQ-036 Overflow: FIFO_DEPTH=4, rxAcceptNewData=0, 10-byte packet, trailCount=2 -> 4 entries held; after releasing ready, last entry keep=0.
REQ-037 Error: 4-byte packet, rxPacketError=1 at end, trailCount=2 -> 2 entries; last entry keep=0.
REQ-038 Short packet: start, one byte, end with trailCount=2 -> no entry, state IDLE one cycle after end.
REQ-039 Ready toggling every cycle across 3 back-to-back packets -> byte order preserved, exactly one last per packet, no loss.
